// File: rtl/disp_regctrl.sv
// disp_regctrl: AXI4-Lite register slave for the display controller.
// Exposes DISPADDR, DISPCTRL (DISPON) and VBLANKSTAT (write-1-to-clear
// turned into a one-cycle CLR_VBLANK pulse). Only address bits [3:2] decode.
// Optional feature: define DISP_SHADOW_EN to double-buffer DISPADDR through
// a shadow register that is transferred to the output on each VBLANK rise.
module disp_regctrl #(
    parameter int C_ADDR_WIDTH = 12,
    parameter int C_FB_ALIGN   = 2
) (
    input  logic                    ACLK,
    input  logic                    ARST,
    input  logic [C_ADDR_WIDTH-1:0] S_AXI_AWADDR,
    input  logic                    S_AXI_AWVALID,
    output logic                    S_AXI_AWREADY,
    input  logic [31:0]             S_AXI_WDATA,
    input  logic [3:0]              S_AXI_WSTRB,
    input  logic                    S_AXI_WVALID,
    output logic                    S_AXI_WREADY,
    output logic [1:0]              S_AXI_BRESP,
    output logic                    S_AXI_BVALID,
    input  logic                    S_AXI_BREADY,
    input  logic [C_ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic                    S_AXI_ARVALID,
    output logic                    S_AXI_ARREADY,
    output logic [31:0]             S_AXI_RDATA,
    output logic [1:0]              S_AXI_RRESP,
    output logic                    S_AXI_RVALID,
    input  logic                    S_AXI_RREADY,
    input  logic                    VBLANK,
    output logic                    CLR_VBLANK,
    output logic [31:0]             DISPADDR,
    output logic                    DISPON
);

    localparam logic [31:0] ALIGN_MASK = ~((32'd1 << C_FB_ALIGN) - 32'd1);

    typedef enum logic {W_IDLE, W_RESP} wState_t;
    typedef enum logic {R_IDLE, R_DATA} rState_t;

    wState_t     wState_q, wState_d;
    rState_t     rState_q, rState_d;

    logic        awHeld_q, awHeld_d;
    logic [1:0]  awAddr_q, awAddr_d;
    logic        wHeld_q, wHeld_d;
    logic [31:0] wData_q, wData_d;
    logic [3:0]  wStrb_q, wStrb_d;

    logic        awHs, wHs, arHs, commit;
    logic [1:0]  cAddr;
    logic [31:0] cData;
    logic [3:0]  cStrb;

    logic [31:0] dispAddr_q;
    logic [31:0] addrStore, addrStore_d;
    logic        dispOn_q, dispOn_d;
    logic        clrVblank_q, clrVblank_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] readMux;

    logic        unusedAddrBits;
    assign unusedAddrBits = ^{S_AXI_AWADDR[C_ADDR_WIDTH-1:4], S_AXI_AWADDR[1:0],
                              S_AXI_ARADDR[C_ADDR_WIDTH-1:4], S_AXI_ARADDR[1:0]};

    assign awHs = S_AXI_AWVALID & S_AXI_AWREADY;
    assign wHs  = S_AXI_WVALID  & S_AXI_WREADY;
    assign arHs = S_AXI_ARVALID & S_AXI_ARREADY;

    // Write FSM state register
    always_ff @(posedge ACLK) begin
        if (ARST) wState_q <= W_IDLE;
        else      wState_q <= wState_d;
    end

    // Write FSM next state: commit moves to response, B handshake returns to idle
    always_comb begin
        wState_d = wState_q;
        case (wState_q)
            W_IDLE: if (commit)       wState_d = W_RESP;
            W_RESP: if (S_AXI_BREADY) wState_d = W_IDLE;
            default:                  wState_d = W_IDLE;
        endcase
    end

    // Write FSM outputs: each half is ready only until it has been captured
    always_comb begin
        S_AXI_AWREADY = (wState_q == W_IDLE) && !awHeld_q;
        S_AXI_WREADY  = (wState_q == W_IDLE) && !wHeld_q;
        S_AXI_BVALID  = (wState_q == W_RESP);
        S_AXI_BRESP   = 2'b00;
    end

    // Commit as soon as both halves are available, taking whichever half
    // arrives this cycle straight from the bus so there is no extra latency
    always_comb begin
        cAddr    = awHs ? S_AXI_AWADDR[3:2] : awAddr_q;
        cData    = wHs  ? S_AXI_WDATA       : wData_q;
        cStrb    = wHs  ? S_AXI_WSTRB       : wStrb_q;
        commit   = (wState_q == W_IDLE) && (awHeld_q || awHs) && (wHeld_q || wHs);
        awHeld_d = awHeld_q;
        awAddr_d = awAddr_q;
        wHeld_d  = wHeld_q;
        wData_d  = wData_q;
        wStrb_d  = wStrb_q;
        if (commit) begin
            awHeld_d = 1'b0;
            wHeld_d  = 1'b0;
        end else begin
            if (awHs) begin
                awHeld_d = 1'b1;
                awAddr_d = S_AXI_AWADDR[3:2];
            end
            if (wHs) begin
                wHeld_d = 1'b1;
                wData_d = S_AXI_WDATA;
                wStrb_d = S_AXI_WSTRB;
            end
        end
    end

    // Register file updates on commit; the clear pulse lasts only the commit cycle
    always_comb begin
        addrStore_d = addrStore;
        for (int b = 0; b < 4; b++) begin
            if (commit && cAddr == 2'd0 && cStrb[b]) begin
                addrStore_d[8*b +: 8] = cData[8*b +: 8];
            end
        end
        addrStore_d = addrStore_d & ALIGN_MASK;
        dispOn_d    = dispOn_q;
        if (commit && cAddr == 2'd1 && cStrb[0]) begin
            dispOn_d = cData[0];
        end
        clrVblank_d = commit && cAddr == 2'd2 && cStrb[0] && cData[0];
    end

    // Write-channel holding registers and control register state
    always_ff @(posedge ACLK) begin
        if (ARST) begin
            awHeld_q    <= 1'b0;
            awAddr_q    <= 2'd0;
            wHeld_q     <= 1'b0;
            wData_q     <= 32'd0;
            wStrb_q     <= 4'd0;
            dispOn_q    <= 1'b0;
            clrVblank_q <= 1'b0;
        end else begin
            awHeld_q    <= awHeld_d;
            awAddr_q    <= awAddr_d;
            wHeld_q     <= wHeld_d;
            wData_q     <= wData_d;
            wStrb_q     <= wStrb_d;
            dispOn_q    <= dispOn_d;
            clrVblank_q <= clrVblank_d;
        end
    end

`ifdef DISP_SHADOW_EN
    logic [31:0] shadow_q;
    logic        vblankPrev_q;
    logic        vblankRise;

    assign addrStore  = shadow_q;
    assign vblankRise = VBLANK & ~vblankPrev_q;

    // Shadow takes CPU writes; the output copies it right after a VBLANK rise
    always_ff @(posedge ACLK) begin
        if (ARST) begin
            shadow_q     <= 32'd0;
            vblankPrev_q <= 1'b0;
            dispAddr_q   <= 32'd0;
        end else begin
            shadow_q     <= addrStore_d;
            vblankPrev_q <= VBLANK;
            if (vblankRise) dispAddr_q <= shadow_q;
        end
    end
`else
    assign addrStore = dispAddr_q;

    // Without a shadow the output register is written directly at commit
    always_ff @(posedge ACLK) begin
        if (ARST) dispAddr_q <= 32'd0;
        else      dispAddr_q <= addrStore_d;
    end
`endif

    // Read FSM state register
    always_ff @(posedge ACLK) begin
        if (ARST) rState_q <= R_IDLE;
        else      rState_q <= rState_d;
    end

    // Read FSM next state: AR handshake to data phase, R handshake back to idle
    always_comb begin
        rState_d = rState_q;
        case (rState_q)
            R_IDLE: if (S_AXI_ARVALID) rState_d = R_DATA;
            R_DATA: if (S_AXI_RREADY)  rState_d = R_IDLE;
            default:                   rState_d = R_IDLE;
        endcase
    end

    // Read FSM outputs
    always_comb begin
        S_AXI_ARREADY = (rState_q == R_IDLE);
        S_AXI_RVALID  = (rState_q == R_DATA);
        S_AXI_RRESP   = 2'b00;
    end

    // Read data is snapshotted from current register values at the AR handshake
    always_comb begin
        case (S_AXI_ARADDR[3:2])
            2'd0:    readMux = addrStore;
            2'd1:    readMux = {31'd0, dispOn_q};
            2'd2:    readMux = {31'd0, VBLANK};
            default: readMux = 32'd0;
        endcase
        rdata_d = arHs ? readMux : rdata_q;
    end

    // Read data register, held stable until the R handshake
    always_ff @(posedge ACLK) begin
        if (ARST) rdata_q <= 32'd0;
        else      rdata_q <= rdata_d;
    end

    assign S_AXI_RDATA = rdata_q;
    assign DISPADDR    = dispAddr_q;
    assign DISPON      = dispOn_q;
    assign CLR_VBLANK  = clrVblank_q;

endmodule

// File: tb/tb_disp_regctrl.sv
// tb_disp_regctrl: directed self-checking bench for disp_regctrl.
// Works with or without DISP_SHADOW_EN; DISPADDR expectations follow a
// small shadow/output model.
module tb_disp_regctrl;

`ifdef DISP_SHADOW_EN
    localparam bit SHADOW_MODE = 1'b1;
`else
    localparam bit SHADOW_MODE = 1'b0;
`endif

    logic        ACLK;
    logic        ARST;
    logic [11:0] S_AXI_AWADDR;
    logic        S_AXI_AWVALID;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_WVALID;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY;
    logic [11:0] S_AXI_ARADDR;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;
    logic        VBLANK;
    logic        CLR_VBLANK;
    logic [31:0] DISPADDR;
    logic        DISPON;

    int          testsRun  = 0;
    int          testsFail = 0;
    int          clrCount  = 0;
    logic        clrAtCommit;
    logic        clrAfter;
    logic [31:0] modelShadow;
    logic [31:0] modelOut;
    logic [31:0] rd;

    disp_regctrl #(.C_ADDR_WIDTH(12), .C_FB_ALIGN(2)) dut (
        .ACLK(ACLK), .ARST(ARST),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
        .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RVALID(S_AXI_RVALID),
        .S_AXI_RREADY(S_AXI_RREADY),
        .VBLANK(VBLANK), .CLR_VBLANK(CLR_VBLANK), .DISPADDR(DISPADDR), .DISPON(DISPON)
    );

    // 100 MHz clock
    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    // Count every cycle in which the clear pulse is high
    always @(posedge ACLK) begin
        if (CLR_VBLANK) clrCount <= clrCount + 1;
    end

    // Safety net so the run can never hang
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Model of a CPU write to the DISPADDR register (alignment 2 -> mask 0x3)
    task automatic modelAddrWrite(input logic [31:0] data, input logic [3:0] strb);
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) modelShadow[8*b +: 8] = data[8*b +: 8];
        end
        modelShadow = modelShadow & 32'hFFFF_FFFC;
        if (!SHADOW_MODE) modelOut = modelShadow;
    endtask

    // Full write: AW and W together, BVALID expected right after the handshake
    task automatic axiWrite(input logic [11:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input string tag);
        bit awDone, wDone, awHs, wHs;
        int n;
        awDone = 0; wDone = 0; n = 0;
        S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b0;
        while (!(awDone && wDone) && n < 20) begin
            awHs = S_AXI_AWVALID && S_AXI_AWREADY;
            wHs  = S_AXI_WVALID && S_AXI_WREADY;
            @(posedge ACLK); #1; n++;
            if (awHs) begin awDone = 1; S_AXI_AWVALID = 1'b0; end
            if (wHs)  begin wDone  = 1; S_AXI_WVALID  = 1'b0; end
        end
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        checkOutput({tag, "_hs"}, {30'd0, awDone, wDone}, 32'd3);
        checkOutput({tag, "_bvalid"}, {31'd0, S_AXI_BVALID}, 32'd1);
        checkOutput({tag, "_bresp"}, {30'd0, S_AXI_BRESP}, 32'd0);
        clrAtCommit = CLR_VBLANK;
        S_AXI_BREADY = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_BREADY = 1'b0;
        clrAfter = CLR_VBLANK;
        checkOutput({tag, "_bdone"}, {31'd0, S_AXI_BVALID}, 32'd0);
    endtask

    // Full read with RREADY raised once RVALID is seen
    task automatic axiRead(input logic [11:0] addr, output logic [31:0] data, input string tag);
        bit done, hs;
        int n;
        done = 0; n = 0;
        S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b0;
        while (!done && n < 20) begin
            hs = S_AXI_ARREADY;
            @(posedge ACLK); #1; n++;
            if (hs) done = 1;
        end
        S_AXI_ARVALID = 1'b0;
        checkOutput({tag, "_arhs"}, {31'd0, done}, 32'd1);
        checkOutput({tag, "_rvalid"}, {31'd0, S_AXI_RVALID}, 32'd1);
        checkOutput({tag, "_rresp"}, {30'd0, S_AXI_RRESP}, 32'd0);
        data = S_AXI_RDATA;
        S_AXI_RREADY = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_RREADY = 1'b0;
        checkOutput({tag, "_rdone"}, {31'd0, S_AXI_RVALID}, 32'd0);
    endtask

    // Drive a VBLANK rise; the shadow (if present) moves to the output
    task automatic raiseVblank(input string tag);
        VBLANK = 1'b1;
        @(posedge ACLK); #1;
        modelOut = modelShadow;
        checkOutput({tag, "_dispaddr"}, DISPADDR, modelOut);
    endtask

    task automatic applyStimulus();
        int c0;

        // Reset values
        ARST = 1'b1;
        repeat (2) @(posedge ACLK);
        #1;
        ARST = 1'b0;
        modelShadow = 32'd0; modelOut = 32'd0;
        checkOutput("rst_dispaddr", DISPADDR, 32'd0);
        checkOutput("rst_dispon", {31'd0, DISPON}, 32'd0);
        checkOutput("rst_clr", {31'd0, CLR_VBLANK}, 32'd0);
        checkOutput("rst_awready", {31'd0, S_AXI_AWREADY}, 32'd1);
        checkOutput("rst_wready", {31'd0, S_AXI_WREADY}, 32'd1);
        checkOutput("rst_arready", {31'd0, S_AXI_ARREADY}, 32'd1);
        checkOutput("rst_bvalid", {31'd0, S_AXI_BVALID}, 32'd0);
        checkOutput("rst_rvalid", {31'd0, S_AXI_RVALID}, 32'd0);
        checkOutput("rst_rdata", S_AXI_RDATA, 32'd0);

        // Byte-lane write and readback
        axiWrite(12'h000, 32'h1234_5678, 4'b0011, "bytelane");
        modelAddrWrite(32'h1234_5678, 4'b0011);
        checkOutput("bytelane_dispaddr", DISPADDR, modelOut);
        axiRead(12'h000, rd, "bytelane_rd");
        checkOutput("bytelane_rdata", rd, 32'h0000_5678);
        raiseVblank("bytelane_vb");
        checkOutput("bytelane_after_vb", DISPADDR, 32'h0000_5678);
        VBLANK = 1'b0;

        // Aliased address, alignment bits forced to zero
        axiWrite(12'h010, 32'hFFFF_FFFF, 4'b1111, "alias");
        modelAddrWrite(32'hFFFF_FFFF, 4'b1111);
        checkOutput("alias_dispaddr", DISPADDR, modelOut);
        axiRead(12'h010, rd, "alias_rd");
        checkOutput("alias_rdata", rd, 32'hFFFF_FFFC);

        // VBLANK status and write-1-to-clear
        raiseVblank("clr_vb");
        axiRead(12'h008, rd, "vbstat_rd");
        checkOutput("vbstat_rdata", rd, 32'd1);
        c0 = clrCount;
        axiWrite(12'h008, 32'h0000_0001, 4'b0001, "clr1");
        checkOutput("clr1_pulse_commit", {31'd0, clrAtCommit}, 32'd1);
        checkOutput("clr1_pulse_after", {31'd0, clrAfter}, 32'd0);
        checkOutput("clr1_pulse_count", clrCount - c0, 32'd1);
        c0 = clrCount;
        axiWrite(12'h008, 32'h0000_0000, 4'b1111, "clr0");
        checkOutput("clr0_pulse_commit", {31'd0, clrAtCommit}, 32'd0);
        checkOutput("clr0_pulse_count", clrCount - c0, 32'd0);
        c0 = clrCount;
        axiWrite(12'h008, 32'h0000_0001, 4'b0000, "clrnostrb");
        checkOutput("clrnostrb_pulse_count", clrCount - c0, 32'd0);
        axiWrite(12'h00C, 32'hFFFF_FFFF, 4'b1111, "resv");
        axiRead(12'h00C, rd, "resv_rd");
        checkOutput("resv_rdata", rd, 32'd0);
        VBLANK = 1'b0;
        axiRead(12'h008, rd, "vbstat0_rd");
        checkOutput("vbstat0_rdata", rd, 32'd0);

        // DISPCTRL: only bit0 stored
        axiWrite(12'h004, 32'hFFFF_FFFF, 4'b1111, "ctrl1");
        checkOutput("ctrl1_dispon", {31'd0, DISPON}, 32'd1);
        axiRead(12'h004, rd, "ctrl1_rd");
        checkOutput("ctrl1_rdata", rd, 32'd1);
        axiWrite(12'h004, 32'h0000_0000, 4'b0001, "ctrl0");
        checkOutput("ctrl0_dispon", {31'd0, DISPON}, 32'd0);

        // Split write: AW first, W four cycles later, BREADY held low
        S_AXI_AWADDR = 12'h000; S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 1'b0;
        checkOutput("split_awready_low", {31'd0, S_AXI_AWREADY}, 32'd0);
        checkOutput("split_wready_high", {31'd0, S_AXI_WREADY}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            checkOutput("split_no_bvalid", {31'd0, S_AXI_BVALID}, 32'd0);
            @(posedge ACLK); #1;
        end
        checkOutput("split_dispaddr_hold", DISPADDR, modelOut);
        S_AXI_WDATA = 32'hAABB_CCDD; S_AXI_WSTRB = 4'b1111; S_AXI_WVALID = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_WVALID = 1'b0;
        modelAddrWrite(32'hAABB_CCDD, 4'b1111);
        checkOutput("split_bvalid", {31'd0, S_AXI_BVALID}, 32'd1);
        checkOutput("split_dispaddr", DISPADDR, modelOut);
        S_AXI_AWADDR = 12'h004; S_AXI_AWVALID = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checkOutput("split_bvalid_held", {31'd0, S_AXI_BVALID}, 32'd1);
            checkOutput("split_no_new_aw", {31'd0, S_AXI_AWREADY}, 32'd0);
            @(posedge ACLK); #1;
        end
        S_AXI_AWVALID = 1'b0;
        S_AXI_BREADY = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_BREADY = 1'b0;
        checkOutput("split_bdone", {31'd0, S_AXI_BVALID}, 32'd0);
        checkOutput("split_awready_back", {31'd0, S_AXI_AWREADY}, 32'd1);
        axiRead(12'h000, rd, "split_rd");
        checkOutput("split_rdata", rd, 32'hAABB_CCDC);

        // Read backpressure while DISPON is written 0 -> 1 in the same cycle
        S_AXI_ARADDR = 12'h004; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b0;
        S_AXI_AWADDR = 12'h004; S_AXI_WDATA = 32'd1; S_AXI_WSTRB = 4'b0001;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_ARVALID = 1'b0; S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        checkOutput("bp_dispon", {31'd0, DISPON}, 32'd1);
        checkOutput("bp_bvalid", {31'd0, S_AXI_BVALID}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            checkOutput("bp_rvalid", {31'd0, S_AXI_RVALID}, 32'd1);
            checkOutput("bp_rdata_old", S_AXI_RDATA, 32'd0);
            checkOutput("bp_arready", {31'd0, S_AXI_ARREADY}, 32'd0);
            @(posedge ACLK); #1;
        end
        S_AXI_BREADY = 1'b0;
        S_AXI_RREADY = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_RREADY = 1'b0;
        checkOutput("bp_rdone", {31'd0, S_AXI_RVALID}, 32'd0);
        axiRead(12'h004, rd, "bp_rd2");
        checkOutput("bp_rdata_new", rd, 32'd1);

        // Reset while a write response is pending
        S_AXI_AWADDR = 12'h004; S_AXI_WDATA = 32'd0; S_AXI_WSTRB = 4'b0001;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b0;
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        checkOutput("midrst_bvalid_pending", {31'd0, S_AXI_BVALID}, 32'd1);
        ARST = 1'b1;
        @(posedge ACLK); #1;
        ARST = 1'b0;
        modelShadow = 32'd0; modelOut = 32'd0;
        checkOutput("midrst_bvalid", {31'd0, S_AXI_BVALID}, 32'd0);
        checkOutput("midrst_awready", {31'd0, S_AXI_AWREADY}, 32'd1);
        checkOutput("midrst_dispaddr", DISPADDR, 32'd0);
        axiWrite(12'h000, 32'h0000_0100, 4'b1111, "postrst");
        modelAddrWrite(32'h0000_0100, 4'b1111);
        checkOutput("postrst_dispaddr", DISPADDR, modelOut);
        axiRead(12'h000, rd, "postrst_rd");
        checkOutput("postrst_rdata", rd, 32'h0000_0100);
    endtask

    initial begin
        ARST = 1'b1;
        S_AXI_AWADDR = '0; S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0;
        S_AXI_BREADY = 1'b0;
        S_AXI_ARADDR = '0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
        VBLANK = 1'b0;
        modelShadow = 32'd0; modelOut = 32'd0;
        applyStimulus();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
        $finish;
    end

endmodule

// File: doc/disp_regctrl.md
# disp_regctrl

AXI4-Lite register slave for the graphic display controller, sitting directly downstream of the VBLANK flag stage. Exposes the frame-buffer base address, the display-enable bit and the VBLANK status to the CPU. Turns a CPU write-1-to-clear into the single-cycle `CLR_VBLANK` pulse that the flag stage consumes. Single outstanding transaction per channel; always responds OKAY.

## Interface
Parameters:
- `C_ADDR_WIDTH`, default 12: AXI address width. Only bits [3:2] are decoded; all other bits are ignored, so the register map aliases.
- `C_FB_ALIGN`, default 2: low `DISPADDR` bits forced to zero (read as 0, writes ignored).

Ports:
- `ACLK` in 1: sole clock.
- `ARST` in 1: reset, synchronous, active-high.
- `S_AXI_AWADDR` in C_ADDR_WIDTH; `S_AXI_AWVALID` in 1; `S_AXI_AWREADY` out 1.
- `S_AXI_WDATA` in 32; `S_AXI_WSTRB` in 4; `S_AXI_WVALID` in 1; `S_AXI_WREADY` out 1.
- `S_AXI_BRESP` out 2; `S_AXI_BVALID` out 1; `S_AXI_BREADY` in 1.
- `S_AXI_ARADDR` in C_ADDR_WIDTH; `S_AXI_ARVALID` in 1; `S_AXI_ARREADY` out 1.
- `S_AXI_RDATA` out 32; `S_AXI_RRESP` out 2; `S_AXI_RVALID` out 1; `S_AXI_RREADY` in 1.
- `VBLANK` in 1: sticky flag from the flag stage.
- `CLR_VBLANK` out 1: one-cycle clear pulse to the flag stage.
- `DISPADDR` out 32: frame-buffer base address to the pixel fetch stage.
- `DISPON` out 1: display enable.

## Operation
Register map, by address bits [3:2]:
- **0: `DISPADDR`**, RW. Byte-lane writes honour `WSTRB`.
- **1: `DISPCTRL`**, RW. Bit0 is `DISPON`, written when `WSTRB[0]=1`. All other bits read 0.
- **2: `VBLANKSTAT`**.
  - Read: bit0 is `VBLANK`.
  - Write with `WSTRB[0]=1` and `WDATA[0]=1`: generates `CLR_VBLANK`.
  - Any other write has no effect.
- **3: reserved.** Reads 0, writes ignored.

Write channel:
- Write FSM states: `W_IDLE`, `W_RESP`.
- AW and W are accepted independently while in `W_IDLE`. Each is latched; `AWREADY`/`WREADY` drop once that half has been captured.
- When both halves are held, the FSM commits the write, asserts `BVALID`, and enters `W_RESP`.
- `W_RESP` → `W_IDLE` on `BVALID & BREADY`. No new AW or W is accepted while in `W_RESP`.

Read channel:
- Read FSM states: `R_IDLE`, `R_DATA`.
- `ARREADY`=1 only in `R_IDLE`.
- On the AR handshake, `RDATA` is captured from current register values and the FSM moves to `R_DATA` with `RVALID`=1.
- `RDATA` and `RVALID` are held stable until `RREADY`.

Common rules:
- `BRESP` and `RRESP` are always 2'b00.
- Read and write channels run concurrently.

## Timing
Reset values (`ARST`=1 at a clock edge):
- `DISPADDR`=0, `DISPON`=0, `CLR_VBLANK`=0.
- `AWREADY`=`WREADY`=`ARREADY`=1.
- `BVALID`=`RVALID`=0, `RDATA`=0.
- Both FSMs return to idle. A transaction in flight is dropped with no response.

Write latency:
- AW and W handshakes in the same cycle t: register updated at edge t+1, `BVALID`=1 from t+1.
- AW and W in different cycles: commit happens one cycle after the later handshake.

`CLR_VBLANK`:
- High for exactly the commit cycle (t+1), never longer.
- The flag stage therefore shows `VBLANK`=0 from t+2.

Read latency:
- AR handshake at cycle t → `RVALID`=1 at t+1.
- `RDATA` reflects the `VBLANK`/register values sampled in cycle t.

Simultaneous events:
- A read and a write to the same register in the same cycle: the read returns the old value.
- A `VBLANK` rise in the same cycle as `CLR_VBLANK`: the flag stage gives clear priority. This block adds no extra handling.
- A back-to-back write is possible at t+2 if `BREADY` was high at t+1.

## Configuration
- **`DISP_SHADOW_EN` defined:**
  - Writes to `DISPADDR` land in a shadow register.
  - The `DISPADDR` output loads from the shadow on the cycle after a `VBLANK` 0→1 transition, detected by a registered compare in this block.
  - Reads of register 0 return the shadow value.
  - Reset clears both the shadow and the output.
- **`DISP_SHADOW_EN` undefined:** writes to `DISPADDR` update the output directly at commit, and there is no shadow register.

## Test plan
1. **Reset values:** assert `ARST` for 2 cycles → all outputs at their reset values and `AWREADY`/`ARREADY`=1.
2. **Byte-lane write and readback:** write 0x12345678 with `WSTRB`=4'b0011 to 0x0 after reset → BRESP=0 and a readback of 0x0 returns 0x00005678. Also `DISPADDR`=0x00005678 at t+1 without the macro, or only after the next `VBLANK` rise with it.
3. **VBLANK clear:** hold `VBLANK`=1, read 0x8 → `RDATA`=1. Then write 0x1 to 0x8 → `CLR_VBLANK` is a single one-cycle pulse at t+1. Writing 0x0 to 0x8 → no pulse.
4. **Split write:** AW at cycle 5, W at cycle 9, `BREADY` held low until cycle 14 → commit at cycle 10, `BVALID` held 10–14, no new AW accepted before cycle 15.
5. **Read backpressure with concurrent write:** read 0x4 with `RREADY` low for 3 cycles while `DISPON` is written 0→1 → `RDATA` stays 0 and stable throughout, and the next read returns 1.
6. **Reset mid-transaction:** assert `ARST` with `BVALID`=1 pending → `BVALID`=0 next cycle, and a subsequent write completes normally.
